// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: ALU control codes and FSM states.
package alu_share_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr+1 (mod NUM_REQ).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between NUM_REQ requesters with round-robin grant and a registered,
// valid/ready response (accept at T, response valid at T+2).
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [4*NUM_REQ-1:0]      req_alu_cntrl,
    input  logic [DATA_W*NUM_REQ-1:0] req_in1,
    input  logic [DATA_W*NUM_REQ-1:0] req_in2,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [((NUM_REQ>1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     gnt_q, gnt_d;
    logic [3:0]          cntrl_q, cntrl_d;
    logic [DATA_W-1:0]   in1_q, in1_d;
    logic [DATA_W-1:0]   in2_q, in2_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_valid;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Unsupported codes yield a clean zero result rather than X.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (cntrl_q)
            ALU_AND: alu_res = in1_q & in2_q;
            ALU_OR:  alu_res = in1_q | in2_q;
            ALU_ADD: alu_res = in1_q + in2_q;
            ALU_SUB: alu_res = in1_q - in2_q;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cntrl_d   = cntrl_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        id_d      = id_q;
        result_d  = result_q;
        zero_d    = zero_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    req_ready = arb_grant;
                    gnt_d     = arb_idx;
                    cntrl_d   = req_alu_cntrl[4*arb_idx +: 4];
                    in1_d     = req_in1[DATA_W*arb_idx +: DATA_W];
                    in2_d     = req_in2[DATA_W*arb_idx +: DATA_W];
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                err_d    = alu_err;
                id_d     = gnt_q;
                ptr_d    = gnt_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= ID_W'(NUM_REQ - 1);
            gnt_q    <= '0;
            cntrl_q  <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            cntrl_q  <= cntrl_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            id_q     <= id_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: grant, latency, round-robin, backpressure, errors, reset.
module tb_alu_share_ctrl;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [4*NUM_REQ-1:0]      req_alu_cntrl;
    logic [DATA_W*NUM_REQ-1:0] req_in1;
    logic [DATA_W*NUM_REQ-1:0] req_in2;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [0:0]                rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic                      rsp_err;
    logic                      busy;

    int n_vec = 0;
    int n_err = 0;

    alu_share_ctrl #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_alu_cntrl (req_alu_cntrl),
        .req_in1       (req_in1),
        .req_in2       (req_in2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_zero      (rsp_zero),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        req_alu_cntrl[4*i +: 4]       = c;
        req_in1[DATA_W*i +: DATA_W]   = a;
        req_in2[DATA_W*i +: DATA_W]   = b;
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] res,
                             input logic zero, input logic err);
        check({tag, "_valid"}, 64'(rsp_valid), 64'(1'b1));
        check({tag, "_id"}, 64'(rsp_id), 64'(id));
        check({tag, "_result"}, 64'(rsp_result), 64'(res));
        check({tag, "_zero"}, 64'(rsp_zero), 64'(zero));
        check({tag, "_err"}, 64'(rsp_err), 64'(err));
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        req_alu_cntrl = '0;
        req_in1       = '0;
        req_in2       = '0;
        rsp_ready     = 1'b0;

        // Reset state
        tick(); #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_result", 64'(rsp_result), 64'd0);
        check("rst_zero", 64'(rsp_zero), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        tick(); reset = 1'b0;

        // Single ADD with wrap: 0xFFFFFFFF + 1 = 0
        tick();
        set_req(0, 4'b0010, 32'hFFFF_FFFF, 32'h1);
        req_valid = 2'b01;
        #1 check("add_ready_T", 64'(req_ready), 64'h1);
        tick(); req_valid = 2'b00;
        #1 check("add_exec_busy", 64'(busy), 64'd1);
        check("add_exec_ready", 64'(req_ready), 64'd0);
        check("add_exec_valid", 64'(rsp_valid), 64'd0);
        tick(); #1;
        check_rsp("add", 1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while the response is pending
        #1 reset = 1'b1;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_ready", 64'(req_ready), 64'd0);
        tick(); reset = 1'b0;

        // Contention: grants alternate 0,1,0,1 from the reset pointer
        rsp_ready = 1'b1;
        set_req(0, 4'b0110, 32'd5, 32'd7);
        set_req(1, 4'b0001, 32'hF0, 32'h0F);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("rr_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick(); #1;
            check($sformatf("rr_exec_ready%0d", k), 64'(req_ready), 64'd0);
            tick(); #1;
            if (k % 2 == 0) check_rsp($sformatf("rr%0d", k), 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
            else            check_rsp($sformatf("rr%0d", k), 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
            tick();
        end

        // Backpressure: response held for five cycles, then next grant follows
        rsp_ready = 1'b0;
        set_req(0, 4'b0010, 32'd2, 32'd3);
        #1 check("bp_grant0", 64'(req_ready), 64'h1);
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check_rsp($sformatf("bp_hold%0d", k), 1'b0, 32'd5, 1'b0, 1'b0);
            check($sformatf("bp_ready%0d", k), 64'(req_ready), 64'd0);
            check($sformatf("bp_busy%0d", k), 64'(busy), 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick(); #1;
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_next_grant", 64'(req_ready), 64'h2);
        tick(); req_valid = 2'b00;
        tick(); #1;
        check_rsp("bp_next", 1'b1, 32'hFF, 1'b0, 1'b0);
        tick();

        // Unsupported control code
        set_req(0, 4'b1111, 32'd3, 32'd4);
        req_valid = 2'b01;
        #1 check("ill_grant", 64'(req_ready), 64'h1);
        tick(); req_valid = 2'b00;
        tick(); #1;
        check_rsp("ill", 1'b0, 32'h0, 1'b1, 1'b1);
        tick();

        // Withdrawn request during EXEC is never granted and does not move the pointer
        set_req(0, 4'b0000, 32'hC, 32'hA);
        req_valid = 2'b01;
        #1 check("wd_grant0", 64'(req_ready), 64'h1);
        tick(); req_valid = 2'b10;
        #1 check("wd_exec_ready", 64'(req_ready), 64'd0);
        tick(); req_valid = 2'b00;
        #1 check_rsp("wd_and", 1'b0, 32'h8, 1'b0, 1'b0);
        tick(); #1;
        check("wd_idle_ready", 64'(req_ready), 64'd0);
        check("wd_idle_busy", 64'(busy), 64'd0);
        tick(); #1;
        check("wd_still_idle", 64'(busy), 64'd0);
        req_valid = 2'b11;
        #1 check("wd_ptr_grant1", 64'(req_ready), 64'h2);
        tick(); req_valid = 2'b00;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
